// File: rtl/acl_pkg.sv
// Shared types and constants for the ACL 5-tuple extractor.
// Holds the tuple layout, ethertype/protocol codes and FSM states.
package acl_pkg;

  localparam int BYTE_W  = 8;
  localparam int TUPLE_W = 104;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;
  localparam logic [7:0]  PROTO_TCP      = 8'd6;
  localparam logic [7:0]  PROTO_UDP      = 8'd17;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  proto;
  } acl_tuple_t;

  typedef enum logic [2:0] {
    ST_ETH,
    ST_IPH,
    ST_L4,
    ST_DRAIN,
    ST_VLAN
  } acl_state_t;

endpackage

// File: rtl/acl_tuple_extractor.sv
// Passive IPv4 5-tuple extractor observing an AXI-Stream byte bus.
// In: clk, rst_n, s_tvalid/s_tready/s_tdata/s_tlast.
// Out: tuple_out, tuple_valid, tuple_count, skip_count.
// Option: ACL_VLAN_EN adds one 802.1Q tag level (shifts offsets by 4).
module acl_tuple_extractor
  import acl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_tvalid,
  input  logic               s_tready,
  input  logic [BYTE_W-1:0]  s_tdata,
  input  logic               s_tlast,
  output logic [TUPLE_W-1:0] tuple_out,
  output logic               tuple_valid,
  output logic [31:0]        tuple_count,
  output logic [31:0]        skip_count
);

  acl_state_t st_q, st_d;
  acl_tuple_t tup_q;

  logic        beat;
  logic [6:0]  cnt_q;
  logic [7:0]  prev_q;
  logic [15:0] etype;
  logic [3:0]  ihl_q;
  logic [7:0]  proto_q;
  logic [31:0] src_q, dst_q, src_d, dst_d;
  logic [15:0] sp_q, dp_q, sp_d, dp_d;
  logic [6:0]  base;
  logic [6:0]  ip_idx;
  logic [6:0]  hdr_last;
  logic [6:0]  l4_idx;
  logic        is_l4;
  logic        ver_ok;
  logic        emit, skip;

`ifdef ACL_VLAN_EN
  logic vlan_q;
  assign base = vlan_q ? 7'd18 : 7'd14;
`else
  assign base = 7'd14;
`endif

  assign beat     = s_tvalid && s_tready;
  assign etype    = {prev_q, s_tdata};
  assign ip_idx   = cnt_q - base;
  assign hdr_last = base + {1'b0, ihl_q, 2'b00} - 7'd1;
  assign l4_idx   = cnt_q - hdr_last - 7'd1;
  assign is_l4    = (proto_q == PROTO_TCP) || (proto_q == PROTO_UDP);
  assign ver_ok   = (s_tdata[7:4] == 4'd4) && (s_tdata[3:0] >= 4'd5);

  // Byte-shift capture; *_d includes the current byte so an
  // emission on the field's last byte sees the complete value.
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    sp_d  = sp_q;
    dp_d  = dp_q;
    if (st_q == ST_IPH && ip_idx[6:2] == 5'd3)
      src_d = {src_q[23:0], s_tdata};
    if (st_q == ST_IPH && ip_idx[6:2] == 5'd4)
      dst_d = {dst_q[23:0], s_tdata};
    if (st_q == ST_L4 && l4_idx[6:1] == 6'd0)
      sp_d = {sp_q[7:0], s_tdata};
    if (st_q == ST_L4 && l4_idx[6:1] == 6'd1)
      dp_d = {dp_q[7:0], s_tdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_ETH;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    emit = 1'b0;
    skip = 1'b0;
    if (beat) begin
      unique case (st_q)
        ST_ETH: begin
          if (s_tlast) begin
            skip = 1'b1;
          end else if (cnt_q == 7'd13) begin
            if (etype == ETHERTYPE_IPV4) begin
              st_d = ST_IPH;
`ifdef ACL_VLAN_EN
            end else if (etype == ETHERTYPE_VLAN) begin
              st_d = ST_VLAN;
`endif
            end else begin
              st_d = ST_DRAIN;
              skip = 1'b1;
            end
          end
        end
`ifdef ACL_VLAN_EN
        ST_VLAN: begin
          if (s_tlast) begin
            st_d = ST_ETH;
            skip = 1'b1;
          end else if (cnt_q == 7'd17) begin
            if (etype == ETHERTYPE_IPV4) begin
              st_d = ST_IPH;
            end else begin
              st_d = ST_DRAIN;
              skip = 1'b1;
            end
          end
        end
`endif
        ST_IPH: begin
          if (ip_idx == 7'd0 && !ver_ok) begin
            skip = 1'b1;
            st_d = s_tlast ? ST_ETH : ST_DRAIN;
          end else if (ip_idx != 7'd0 && cnt_q == hdr_last && !is_l4) begin
            emit = 1'b1;
            st_d = s_tlast ? ST_ETH : ST_DRAIN;
          end else if (s_tlast) begin
            skip = 1'b1;
            st_d = ST_ETH;
          end else if (ip_idx != 7'd0 && cnt_q == hdr_last) begin
            st_d = ST_L4;
          end
        end
        ST_L4: begin
          if (l4_idx == 7'd3) begin
            emit = 1'b1;
            st_d = s_tlast ? ST_ETH : ST_DRAIN;
          end else if (s_tlast) begin
            skip = 1'b1;
            st_d = ST_ETH;
          end
        end
        ST_DRAIN: begin
          if (s_tlast) st_d = ST_ETH;
        end
        default: st_d = ST_ETH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      prev_q      <= '0;
      ihl_q       <= '0;
      proto_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      sp_q        <= '0;
      dp_q        <= '0;
      tup_q       <= '0;
      tuple_valid <= 1'b0;
      tuple_count <= '0;
      skip_count  <= '0;
`ifdef ACL_VLAN_EN
      vlan_q      <= 1'b0;
`endif
    end else begin
      tuple_valid <= emit;
      if (beat) begin
        prev_q <= s_tdata;
        if (s_tlast)
          cnt_q <= '0;
        else if (cnt_q != 7'd127)
          cnt_q <= cnt_q + 7'd1;
        src_q <= src_d;
        dst_q <= dst_d;
        sp_q  <= sp_d;
        dp_q  <= dp_d;
        if (st_q == ST_IPH && ip_idx == 7'd9)
          proto_q <= s_tdata;
        if (st_q == ST_IPH && ip_idx == 7'd0)
          ihl_q <= s_tdata[3:0];
`ifdef ACL_VLAN_EN
        if (st_q == ST_ETH)  vlan_q <= 1'b0;
        if (st_q == ST_VLAN) vlan_q <= 1'b1;
`endif
      end
      if (emit) begin
        tup_q.src_ip   <= src_d;
        tup_q.dst_ip   <= dst_d;
        tup_q.src_port <= (st_q == ST_L4) ? sp_d : 16'd0;
        tup_q.dst_port <= (st_q == ST_L4) ? dp_d : 16'd0;
        tup_q.proto    <= proto_q;
        tuple_count    <= tuple_count + 32'd1;
      end
      if (skip)
        skip_count <= skip_count + 32'd1;
    end
  end

  assign tuple_out = tup_q;

endmodule

// File: tb/tb_acl_tuple_extractor.sv
// Self-checking bench for acl_tuple_extractor.
// Frames are built as byte queues; expected tuples go to a scoreboard.
module tb_acl_tuple_extractor;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready = 1'b0;
  logic [7:0]   s_tdata = 8'd0;
  logic         s_tlast = 1'b0;
  logic [103:0] tuple_out;
  logic         tuple_valid;
  logic [31:0]  tuple_count;
  logic [31:0]  skip_count;

  acl_tuple_extractor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata     (s_tdata),
    .s_tlast     (s_tlast),
    .tuple_out   (tuple_out),
    .tuple_valid (tuple_valid),
    .tuple_count (tuple_count),
    .skip_count  (skip_count)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int exp_tcnt = 0;
  int exp_skip = 0;
  bit hold_pend = 1'b0;
  logic [103:0] last_tup = '0;
  logic [7:0]   frm[$];
  logic [103:0] exp_tup[$];
  int           exp_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [103:0] obs,
                     input logic [103:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hold_pend) begin
      chk("hold_tuple", tuple_out, last_tup);
      chk("strobe_1cyc", {103'd0, tuple_valid}, 104'd0);
      hold_pend = 1'b0;
    end
    if (rst_n && tuple_valid) begin
      if (exp_tup.size() == 0) begin
        chk("unexpected_tuple", {103'd0, tuple_valid}, 104'd0);
      end else begin
        last_tup = exp_tup.pop_front();
        chk("tuple", tuple_out, last_tup);
        chk("tuple_cyc", 104'(cyc), 104'(exp_cyc.pop_front()));
        exp_tcnt++;
        chk("tuple_count", 104'(tuple_count), 104'(exp_tcnt));
        hold_pend = 1'b1;
      end
    end
  end

  task automatic mk(input logic [15:0] et, input bit vl,
                    input logic [7:0] vihl, input logic [7:0] pr,
                    input logic [31:0] sa, input logic [31:0] da,
                    input logic [15:0] sp, input logic [15:0] dp,
                    input int cut);
    logic [7:0] b[$];
    for (int i = 0; i < 12; i++) b.push_back(8'(i + 1));
    if (vl) begin
      b.push_back(8'h81); b.push_back(8'h00);
      b.push_back(8'h00); b.push_back(8'h05);
    end
    b.push_back(et[15:8]); b.push_back(et[7:0]);
    b.push_back(vihl); b.push_back(8'h00);
    b.push_back(8'h00); b.push_back(8'h40);
    b.push_back(8'h12); b.push_back(8'h34);
    b.push_back(8'h40); b.push_back(8'h00);
    b.push_back(8'h40); b.push_back(pr);
    b.push_back(8'hAB); b.push_back(8'hCD);
    for (int i = 3; i >= 0; i--) b.push_back(sa[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(da[i*8 +: 8]);
    for (int i = 20; i < int'(vihl[3:0]) * 4; i++)
      b.push_back(8'($urandom));
    b.push_back(sp[15:8]); b.push_back(sp[7:0]);
    b.push_back(dp[15:8]); b.push_back(dp[7:0]);
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    if (cut > 0)
      while (b.size() > cut) void'(b.pop_back());
    frm = b;
  endtask

  task automatic send(input bit gaps, input int emit_idx);
    for (int i = 0; i < frm.size(); i++) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clk);
          s_tvalid = 1'($urandom_range(0, 1));
          s_tready = ~s_tvalid;
          s_tdata  = 8'($urandom);
          s_tlast  = 1'($urandom_range(0, 1));
        end
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tready = 1'b1;
      s_tdata  = frm[i];
      s_tlast  = (i == frm.size() - 1);
      if (i == emit_idx) exp_cyc.push_back(cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tready = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tuple", tuple_out, 104'd0);
    chk("rst_valid", {103'd0, tuple_valid}, 104'd0);
    chk("rst_tcount", 104'(tuple_count), 104'd0);
    chk("rst_skip", 104'(skip_count), 104'd0);
    rst_n = 1'b1;
    idle(2);

    mk(16'h0800, 0, 8'h45, 8'd6, 32'hC0A8010A, 32'h0A000001,
       16'h1234, 16'h0050, 0);
    exp_tup.push_back({32'hC0A8010A, 32'h0A000001, 16'h1234,
                       16'h0050, 8'h06});
    send(0, 37);
    idle(3);
    chk("tcp_literal", tuple_out, 104'hC0A8010A0A0000011234005006);
    chk("tcp_tcount", 104'(tuple_count), 104'd1);
    chk("tcp_skip", 104'(skip_count), 104'(exp_skip));

    mk(16'h0800, 0, 8'h46, 8'd1, 32'h01020304, 32'h05060708,
       16'hFFFF, 16'hEEEE, 0);
    exp_tup.push_back({32'h01020304, 32'h05060708, 32'd0, 8'h01});
    send(0, 37);
    idle(3);

    mk(16'h0806, 0, 8'h45, 8'd17, 32'h11111111, 32'h22222222,
       16'h3333, 16'h4444, 0);
    send(0, -1);
    exp_skip++;
    mk(16'h0800, 0, 8'h45, 8'd17, 32'hAC100001, 32'hAC100002,
       16'h0035, 16'hC350, 0);
    exp_tup.push_back({32'hAC100001, 32'hAC100002, 16'h0035,
                       16'hC350, 8'h11});
    send(0, 37);
    idle(3);
    chk("arp_skip", 104'(skip_count), 104'(exp_skip));

    mk(16'h0800, 0, 8'h45, 8'd6, 32'hDEADBEEF, 32'hCAFEF00D,
       16'h0101, 16'h0202, 36);
    send(0, -1);
    exp_skip++;
    idle(4);
    chk("trunc_skip", 104'(skip_count), 104'(exp_skip));
    chk("trunc_held", tuple_out, last_tup);

    mk(16'h0800, 0, 8'h45, 8'd6, 32'h0B0B0B0B, 32'h0C0C0C0C,
       16'h0D0D, 16'h0E0E, 0);
    exp_tup.push_back({32'h0B0B0B0B, 32'h0C0C0C0C, 16'h0D0D,
                       16'h0E0E, 8'h06});
    send(0, 37);
    idle(3);

    mk(16'h0800, 0, 8'h45, 8'd6, 32'hC0A8010A, 32'h0A000001,
       16'h1234, 16'h0050, 0);
    exp_tup.push_back({32'hC0A8010A, 32'h0A000001, 16'h1234,
                       16'h0050, 8'h06});
    send(1, 37);
    idle(3);

    mk(16'h0800, 1, 8'h45, 8'd17, 32'h0A0A0A01, 32'h0A0A0A02,
       16'h1F90, 16'h0BB8, 0);
`ifdef ACL_VLAN_EN
    exp_tup.push_back({32'h0A0A0A01, 32'h0A0A0A02, 16'h1F90,
                       16'h0BB8, 8'h11});
    send(0, 41);
`else
    send(0, -1);
    exp_skip++;
`endif
    idle(3);
    chk("vlan_skip", 104'(skip_count), 104'(exp_skip));

    mk(16'h8100, 1, 8'h45, 8'd17, 32'h1, 32'h2, 16'h3, 16'h4, 0);
    send(0, -1);
    exp_skip++;
    mk(16'h0800, 0, 8'h65, 8'd6, 32'h1, 32'h2, 16'h3, 16'h4, 0);
    send(0, -1);
    exp_skip++;
    mk(16'h0800, 0, 8'h44, 8'd6, 32'h1, 32'h2, 16'h3, 16'h4, 0);
    send(0, -1);
    exp_skip++;
    idle(3);
    chk("bad_hdr_skip", 104'(skip_count), 104'(exp_skip));

    mk(16'h0800, 0, 8'h45, 8'd6, 32'h9, 32'h8, 16'h7, 16'h6, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tready = 1'b1;
      s_tdata  = frm[i];
      s_tlast  = 1'b0;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tuple", tuple_out, 104'd0);
    chk("mid_rst_tcount", 104'(tuple_count), 104'd0);
    chk("mid_rst_skip", 104'(skip_count), 104'd0);
    exp_tcnt = 0;
    exp_skip = 0;
    last_tup = '0;
    rst_n = 1'b1;
    idle(2);
    mk(16'h0800, 0, 8'h45, 8'd17, 32'h64646464, 32'hC8C8C8C8,
       16'h0007, 16'h0009, 0);
    exp_tup.push_back({32'h64646464, 32'hC8C8C8C8, 16'h0007,
                       16'h0009, 8'h11});
    send(0, 37);
    idle(2);

    for (int i = 0; i < 200 && exp_tup.size() != 0; i++)
      @(negedge clk);
    chk("scoreboard_empty", 104'(exp_tup.size()), 104'd0);
    chk("final_skip", 104'(skip_count), 104'(exp_skip));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/acl_tuple_extractor.md
# acl_tuple_extractor

Passive parser between the ingress AXI-Stream byte bus and the ACL match engine. It monitors Ethernet frames and pulls out the IPv4 5-tuple: source IP, destination IP, source port, destination port and protocol. It then presents the tuple as a 104-bit word with a one-cycle valid strobe, which the match engine hashes and compares. The block never stalls the stream; it only observes accepted beats.

## Interface
- No parameters. Widths are fixed by the shared package: byte data is 8 bits, the tuple is 104 bits.
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- s_tvalid  in  1  observed stream valid.
- s_tready  in  1  observed stream ready. A beat is accepted when s_tvalid && s_tready.
- s_tdata  in  8  observed frame byte; byte 0 is the first destination-MAC byte.
- s_tlast  in  1  last byte of frame.
- tuple_out  out  104  {src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], proto[7:0]}. Held stable until the next emission.
- tuple_valid  out  1  single-cycle strobe marking a new tuple_out.
- tuple_count  out  32  number of tuples emitted; wraps modulo 2^32.
- skip_count  out  32  number of frames dropped as non-IPv4, malformed or truncated; wraps modulo 2^32.

## Operation
- Beat counter: 7 bits, saturates at 127, cleared on every accepted beat with s_tlast. Non-beat cycles change nothing.
- The FSM has 5 states, listed below.
- ETH: parses bytes 0–13. Bytes 12–13 form the ethertype.
  - 0x0800 → IPH.
  - Any other value → DRAIN, skip_count+1.
- IPH: parses the IP header.
  - IP byte 0: version must be 4 and IHL must be ≥5; otherwise → DRAIN, skip_count+1.
  - IP byte 9 captures proto. IP bytes 12–15 capture src_ip; bytes 16–19 capture dst_ip.
  - At IP byte IHL*4−1: if proto is 6 or 17 → L4. Otherwise emit the tuple with both ports zero.
- L4: L4 bytes 0–1 form src_port and bytes 2–3 form dst_port. Emission happens on L4 byte 3.
- DRAIN: ignores bytes until s_tlast, then → ETH.
- Emission: load tuple_out, pulse tuple_valid, tuple_count+1. If the emitting beat also carries s_tlast → ETH, otherwise → DRAIN.
- Truncation: s_tlast in ETH, IPH or L4 before emission → ETH, skip_count+1, no emission, tuple_out unchanged.
- IP options between byte 20 and IHL*4−1 are skipped. The IHL upper bound of 60 bytes keeps every offset below 127.
- Field bytes are big-endian in network order: the first received byte becomes the MSB.

## Timing
- tuple_valid is registered and is high in the cycle after the completing beat.
- tuple_out changes in the same edge that raises tuple_valid and is held afterwards. The match engine samples it one cycle after the strobe, so it must not move then.
- Minimum tuple spacing:
  - TCP/UDP: 38 beats.
  - Non-TCP/UDP: 34 beats.
  - Back-to-back frames with no idle cycles are legal.
- Reset values: tuple_out 0, tuple_valid 0, both counters 0, FSM in ETH, beat counter 0.
- Reset is shared with the MAC, so no mid-frame beats arrive after deassertion. A reset asserted mid-frame discards all partial capture.
- If a counter increments at the same edge it wraps, it goes from 0xFFFFFFFF to 0.

## Configuration
- ACL_VLAN_EN defined:
  - In ETH, ethertype 0x8100 moves to a VLAN state that consumes 4 bytes. TCI is ignored.
  - The inner ethertype is then checked with the same 0x0800 rule, and all later offsets shift by 4.
  - A second 0x8100 tag → DRAIN, skip_count+1.
- ACL_VLAN_EN undefined: 0x8100 is treated as non-IPv4 → skip. The VLAN state is not compiled.

## Structure
- Shared package acl_pkg holds:
  - acl_tuple_t, a packed struct in the tuple_out field order, 104 bits.
  - Constants ETHERTYPE_IPV4 = 16'h0800, ETHERTYPE_VLAN = 16'h8100, PROTO_TCP = 8'd6, PROTO_UDP = 8'd17.
  - The FSM state enum.
- Single module with no sub-module. Capture registers are byte-shift registers enabled per field window.

## Test plan
- TCP frame: src C0A8010A, dst 0A000001, ports 1234/0050, IHL 5 → tuple_out 0xC0A8010A0A000001123400500_6, i.e. fields C0A8010A,0A000001,1234,0050,06. tuple_valid high for 1 cycle at beat 37+1; tuple_count 1.
- ICMP frame, proto 1, with IHL 6 → tuple emitted with ports 0000 one cycle after beat 37 (IP byte 23); bytes 20–23 are ignored.
- ARP frame, ethertype 0806, followed back-to-back by a UDP frame → skip_count 1, then a correct UDP tuple with no idle cycles between frames.
- TCP frame cut with s_tlast at L4 byte 1 → no tuple_valid, skip_count+1; the previous tuple_out is held. The next frame parses normally.
- Gaps: s_tvalid toggled and s_tready low for random cycles → same tuple as the gap-free run; tuple_valid follows the final accepted beat by exactly 1 cycle.
- VLAN frame (0x8100, VID 5, then 0x0800 UDP):
  - With ACL_VLAN_EN → tuple correct, emitted at beat 41+1.
  - Without ACL_VLAN_EN → skip_count+1.
